// File: rtl/uart_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_pkg
//   Shared types and helpers for the uart_tx arbiter slice.
//   - arb_state_e   : arbiter FSM state encoding (idle / packet transfer)
//   - DefTimeoutCyc : default idle-cycle budget inside a packet before forced
//                     release (only used when UART_ARB_TIMEOUT_EN is defined)
//   - idx_w()       : index width for an N-entry one-hot, never less than 1
//   - cnt_w()       : idle counter width, at least MinIdleCntW bits
// -----------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

   typedef enum logic [0:0] {
      StIdle = 1'b0,
      StXfer = 1'b1
   } arb_state_e;

   localparam int unsigned DefTimeoutCyc = 50000;
   localparam int unsigned MinIdleCntW   = 16;

   // Width needed to index n entries; a single entry still gets one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      int unsigned w;
      w = (n > 1) ? unsigned'($clog2(n)) : 1;
      return w;
   endfunction

   // Counter must hold cyc itself, and is never narrower than MinIdleCntW.
   function automatic int unsigned cnt_w(input int unsigned cyc);
      int unsigned w;
      w = unsigned'($clog2(cyc + 1));
      if (w < MinIdleCntW) begin
         w = MinIdleCntW;
      end
      return w;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_rr_pick
//   Combinational round-robin selector. Starting at index ptr and searching
//   upward with wrap-around, picks the first asserted request bit.
//   Kept standalone so the rx dispatch path can reuse it.
// Ports
//   req    in   P_REQ_NUM   request vector
//   ptr    in   P_IDX_W     search start index (must be < P_REQ_NUM)
//   grant  out  P_REQ_NUM   one-hot of the chosen request, 0 if none
//   idx    out  P_IDX_W     binary index of the chosen request, 0 if none
//   found  out  1           at least one request is asserted
// -----------------------------------------------------------------------------
module uart_tx_arbiter_rr_pick
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned P_REQ_NUM = 4,
   parameter int unsigned P_IDX_W   = idx_w(P_REQ_NUM)
) (
   input  logic [P_REQ_NUM-1:0] req,
   input  logic [P_IDX_W-1:0]   ptr,
   output logic [P_REQ_NUM-1:0] grant,
   output logic [P_IDX_W-1:0]   idx,
   output logic                 found
);

   always_comb begin
      int unsigned k;
      logic [P_IDX_W-1:0] k_idx;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      k     = 0;
      k_idx = '0;
      for (int unsigned i = 0; i < P_REQ_NUM; i++) begin
         // Candidate index (ptr + i) mod N; ptr < N so one subtraction suffices.
         k = 32'(ptr) + i;
         if (k >= P_REQ_NUM) begin
            k = k - P_REQ_NUM;
         end
         k_idx = P_IDX_W'(k);
         if (!found && req[k_idx]) begin
            found        = 1'b1;
            grant[k_idx] = 1'b1;
            idx          = k_idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one uart_tx byte channel among P_REQ_NUM byte-stream requesters
//   with packet-locked round-robin arbitration: once granted, a requester
//   owns the channel until it transfers a byte flagged last. Data passes
//   through unaltered; the arbiter only sequences access.
//
//   Optional feature (macro UART_ARB_TIMEOUT_EN): an idle counter inside a
//   packet forces release after P_TIMEOUT_CYC cycles without a beat and
//   pulses o_timeout for one cycle. Without the macro o_timeout is tied 0.
//
// Ports
//   i_clk            in   1      system clock
//   i_rst            in   1      asynchronous, active-high reset
//   i_req_valid      in   N      per-requester byte valid
//   i_req_data       in   N*W    requester k's byte in [k*W +: W]
//   i_req_last       in   N      byte is the last of its packet
//   o_req_ready      out  N      per-requester accept (owner only)
//   o_uart_tx_data   out  W      byte to uart_tx
//   o_uart_tx_valid  out  1      byte valid to uart_tx
//   i_uart_tx_ready  in   1      uart_tx can accept a byte
//   o_grant          out  N      one-hot current owner, 0 when idle
//   o_busy           out  1      a packet is in progress
//   o_timeout        out  1      one-cycle pulse on forced release
// -----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned P_REQ_NUM         = 4,
   parameter int unsigned P_UART_DATA_WIDTH = 8,
   parameter int unsigned P_TIMEOUT_CYC     = DefTimeoutCyc
) (
   input  logic                                   i_clk,
   input  logic                                   i_rst,
   input  logic [P_REQ_NUM-1:0]                   i_req_valid,
   input  logic [P_REQ_NUM*P_UART_DATA_WIDTH-1:0] i_req_data,
   input  logic [P_REQ_NUM-1:0]                   i_req_last,
   output logic [P_REQ_NUM-1:0]                   o_req_ready,
   output logic [P_UART_DATA_WIDTH-1:0]           o_uart_tx_data,
   output logic                                   o_uart_tx_valid,
   input  logic                                   i_uart_tx_ready,
   output logic [P_REQ_NUM-1:0]                   o_grant,
   output logic                                   o_busy,
   output logic                                   o_timeout
);

   localparam int unsigned N  = P_REQ_NUM;
   localparam int unsigned W  = P_UART_DATA_WIDTH;
   localparam int unsigned IW = idx_w(P_REQ_NUM);

   arb_state_e      state_q, state_d;
   logic [N-1:0]    grant_q, grant_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   ptr_q, ptr_d;

   logic [N-1:0]    pick_grant;
   logic [IW-1:0]   pick_idx;
   logic            pick_found;

   logic            xfer;
   logic            owner_valid;
   logic            owner_last;
   logic            beat;
   logic            idle_hit;
   logic [IW-1:0]   owner_next;
   logic [W-1:0]    owner_data;

   // ---------------------------------------------------------------------------
   // Round-robin choice, only consumed while idle
   // ---------------------------------------------------------------------------
   uart_tx_arbiter_rr_pick #(
      .P_REQ_NUM (N),
      .P_IDX_W   (IW)
   ) u_rr_pick (
      .req   (i_req_valid),
      .ptr   (ptr_q),
      .grant (pick_grant),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // ---------------------------------------------------------------------------
   // Owner-side datapath (purely combinational, no added latency)
   // ---------------------------------------------------------------------------
   assign xfer        = (state_q == StXfer);
   assign owner_valid = i_req_valid[owner_q];
   assign owner_last  = i_req_last[owner_q];
   assign beat        = xfer & owner_valid & i_uart_tx_ready;

   // Pointer advances to the requester after the releasing owner, with wrap.
   assign owner_next  = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;

   always_comb begin
      owner_data = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (owner_q == IW'(k)) begin
            owner_data = i_req_data[k*W +: W];
         end
      end
   end

   assign o_uart_tx_data  = owner_data;
   assign o_uart_tx_valid = xfer & owner_valid;
   // grant_q is zero whenever idle, so ready is naturally gated to the owner.
   assign o_req_ready     = grant_q & {N{i_uart_tx_ready}};
   assign o_grant         = grant_q;
   assign o_busy          = xfer;

   // ---------------------------------------------------------------------------
   // Optional in-packet idle timeout
   // ---------------------------------------------------------------------------
`ifdef UART_ARB_TIMEOUT_EN
   localparam int unsigned CW = cnt_w(P_TIMEOUT_CYC);

   logic [CW-1:0] idle_cnt_q, idle_cnt_d;
   logic          timeout_q;

   // Fires on the cycle that would bring the idle count to P_TIMEOUT_CYC.
   assign idle_hit = xfer & ~beat & (idle_cnt_q == CW'(P_TIMEOUT_CYC - 1));

   always_comb begin
      idle_cnt_d = idle_cnt_q;
      // Cleared while idle (so every new grant starts at 0) and on each beat.
      if (!xfer || beat || idle_hit) begin
         idle_cnt_d = '0;
      end else begin
         idle_cnt_d = idle_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         idle_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
         timeout_q  <= idle_hit;
      end
   end

   assign o_timeout = timeout_q;
`else
   assign idle_hit  = 1'b0;
   assign o_timeout = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Arbiter FSM
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      case (state_q)
         StIdle: begin
            if (pick_found) begin
               grant_d = pick_grant;
               owner_d = pick_idx;
               state_d = StXfer;
            end
         end
         StXfer: begin
            if ((beat && owner_last) || idle_hit) begin
               grant_d = '0;
               ptr_d   = owner_next;
               state_d = StIdle;
            end
         end
         default: begin
            grant_d = '0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= StIdle;
         grant_q <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (4 requesters, 8-bit bytes,
//   P_TIMEOUT_CYC=20). Inputs change on the falling edge; outputs are
//   sampled 1 time unit later, before the next rising edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic [W-1:0]   uart_data;
   logic           uart_valid;
   logic           uart_ready;
   logic [N-1:0]   grant;
   logic           busy;
   logic           timeout;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .P_REQ_NUM         (N),
      .P_UART_DATA_WIDTH (W),
      .P_TIMEOUT_CYC     (20)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_req_valid     (req_valid),
      .i_req_data      (req_data),
      .i_req_last      (req_last),
      .o_req_ready     (req_ready),
      .o_uart_tx_data  (uart_data),
      .o_uart_tx_valid (uart_valid),
      .i_uart_tx_ready (uart_ready),
      .o_grant         (grant),
      .o_busy          (busy),
      .o_timeout       (timeout)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [3:0]  last;
      logic        ready;
      logic [31:0] data;
      logic [3:0]  e_grant;
      logic        e_uvalid;
      logic [7:0]  e_udata;
      logic [3:0]  e_rdy;
      logic        e_busy;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic [3:0] v, input logic [3:0] l,
                               input logic rd, input logic [31:0] d, input logic [3:0] g,
                               input logic uv, input logic [7:0] ud, input logic [3:0] rr,
                               input logic b);
      vec_t t;
      t.rst = r;  t.valid = v;  t.last = l;  t.ready = rd;  t.data = d;
      t.e_grant = g;  t.e_uvalid = uv;  t.e_udata = ud;  t.e_rdy = rr;  t.e_busy = b;
      vecs.push_back(t);
   endfunction

   logic [7:0] got_q[$];
   int         to_seen;
   int         n_wait;
   bit         found;

   task automatic sample_beat();
      if (uart_valid && uart_ready) got_q.push_back(uart_data);
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = '0;
      req_last   = '0;
      req_data   = '0;
      uart_ready = 1'b1;

      // Reset with every requester asking: nothing may be granted.
      add(1, 4'hF, 4'h0, 1, 32'h0,         4'h0, 0, 8'h00, 4'h0, 0);
      // Single packet from req1: 41 42 43 (last on 43), then pointer = 2.
      add(0, 4'h2, 4'h0, 1, 32'h0000_4100, 4'h0, 0, 8'h00, 4'h0, 0);
      add(0, 4'h2, 4'h0, 1, 32'h0000_4100, 4'h2, 1, 8'h41, 4'h2, 1);
      add(0, 4'h2, 4'h0, 1, 32'h0000_4200, 4'h2, 1, 8'h42, 4'h2, 1);
      add(0, 4'h2, 4'h2, 1, 32'h0000_4300, 4'h2, 1, 8'h43, 4'h2, 1);
      add(0, 4'h0, 4'h0, 1, 32'h0,         4'h0, 0, 8'h00, 4'h0, 0);
      // Pointer = 2 with req0/req1 waiting: search 2,3,0 -> req0 wins.
      add(0, 4'h3, 4'h1, 1, 32'h0000_0055, 4'h0, 0, 8'h00, 4'h0, 0);
      add(0, 4'h3, 4'h1, 1, 32'h0000_0055, 4'h1, 1, 8'h55, 4'h1, 1);
      add(0, 4'h2, 4'h2, 1, 32'h0000_4400, 4'h0, 0, 8'h00, 4'h0, 0);
      add(0, 4'h2, 4'h2, 1, 32'h0000_4400, 4'h2, 1, 8'h44, 4'h2, 1);
      add(0, 4'h0, 4'h0, 1, 32'h0,         4'h0, 0, 8'h00, 4'h0, 0);
      // Contention after reset, valid=1011, 1-byte packets: order 0,1,3,0.
      add(1, 4'hB, 4'hB, 1, 32'hA300_A1A0, 4'h0, 0, 8'h00, 4'h0, 0);
      add(0, 4'hB, 4'hB, 1, 32'hA300_A1A0, 4'h0, 0, 8'h00, 4'h0, 0);
      add(0, 4'hB, 4'hB, 1, 32'hA300_A1A0, 4'h1, 1, 8'hA0, 4'h1, 1);
      add(0, 4'hB, 4'hB, 1, 32'hA300_A1A0, 4'h0, 0, 8'h00, 4'h0, 0);
      add(0, 4'hB, 4'hB, 1, 32'hA300_A1A0, 4'h2, 1, 8'hA1, 4'h2, 1);
      add(0, 4'hB, 4'hB, 1, 32'hA300_A1A0, 4'h0, 0, 8'h00, 4'h0, 0);
      add(0, 4'hB, 4'hB, 1, 32'hA300_A1A0, 4'h8, 1, 8'hA3, 4'h8, 1);
      add(0, 4'hB, 4'hB, 1, 32'hA300_A1A0, 4'h0, 0, 8'h00, 4'h0, 0);
      add(0, 4'hB, 4'hB, 1, 32'hA300_A1A0, 4'h1, 1, 8'hA0, 4'h1, 1);
      add(0, 4'h0, 4'h0, 1, 32'h0,         4'h0, 0, 8'h00, 4'h0, 0);
      // Reset after byte 2 of 4 from req2; afterwards pointer is back at 0.
      add(0, 4'h4, 4'h0, 1, 32'h00B1_0000, 4'h0, 0, 8'h00, 4'h0, 0);
      add(0, 4'h4, 4'h0, 1, 32'h00B1_0000, 4'h4, 1, 8'hB1, 4'h4, 1);
      add(0, 4'h4, 4'h0, 1, 32'h00B2_0000, 4'h4, 1, 8'hB2, 4'h4, 1);
      add(1, 4'hC, 4'h0, 1, 32'h00B3_0000, 4'h0, 0, 8'h00, 4'h0, 0);
      add(0, 4'h9, 4'h9, 1, 32'hC300_00C0, 4'h0, 0, 8'h00, 4'h0, 0);
      add(0, 4'h9, 4'h9, 1, 32'hC300_00C0, 4'h1, 1, 8'hC0, 4'h1, 1);
      add(0, 4'h9, 4'h9, 1, 32'hC300_00C0, 4'h0, 0, 8'h00, 4'h0, 0);
      add(0, 4'h9, 4'h9, 1, 32'hC300_00C0, 4'h8, 1, 8'hC3, 4'h8, 1);
      add(0, 4'h0, 4'h0, 1, 32'h0,         4'h0, 0, 8'h00, 4'h0, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst        = vecs[i].rst;
         req_valid  = vecs[i].valid;
         req_last   = vecs[i].last;
         uart_ready = vecs[i].ready;
         req_data   = vecs[i].data;
         #1;
         chk($sformatf("row%0d grant", i), 32'(grant), 32'(vecs[i].e_grant));
         chk($sformatf("row%0d uart_valid", i), 32'(uart_valid), 32'(vecs[i].e_uvalid));
         chk($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
         chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].e_busy));
         chk($sformatf("row%0d timeout", i), 32'(timeout), 32'h0);
         if (vecs[i].e_uvalid) begin
            chk($sformatf("row%0d uart_data", i), 32'(uart_data), 32'(vecs[i].e_udata));
         end
      end

      // Backpressure: req2 sends 61 62 63 with ready low for 10 cycles on 62.
      got_q.delete();
      @(negedge clk);
      req_valid = 4'h4; req_last = 4'h0; req_data = 32'h0061_0000; uart_ready = 1'b1;
      #1; chk("bp idle grant", 32'(grant), 32'h0); sample_beat();
      @(negedge clk);
      #1; chk("bp first grant", 32'(grant), 32'h4); sample_beat();
      @(negedge clk);
      req_data = 32'h0062_0000; uart_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("bp hold%0d grant", i), 32'(grant), 32'h4);
         chk($sformatf("bp hold%0d data", i), 32'(uart_data), 32'h62);
         chk($sformatf("bp hold%0d ready", i), 32'(req_ready), 32'h0);
         sample_beat();
         @(negedge clk);
      end
      uart_ready = 1'b1;
      #1; chk("bp release ready", 32'(req_ready), 32'h4); sample_beat();
      @(negedge clk);
      req_data = 32'h0063_0000; req_last = 4'h4;
      #1; sample_beat();
      @(negedge clk);
      req_valid = 4'h0; req_last = 4'h0;
      #1; chk("bp end grant", 32'(grant), 32'h0); chk("bp end busy", 32'(busy), 32'h0);
      chk("bp beat count", 32'(got_q.size()), 32'd3);
      if (got_q.size() == 3) begin
         chk("bp beat0", 32'(got_q[0]), 32'h61);
         chk("bp beat1", 32'(got_q[1]), 32'h62);
         chk("bp beat2", 32'(got_q[2]), 32'h63);
      end

      // Owner drops valid mid-packet while req1 waits.
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      req_valid = 4'h3; req_last = 4'h0; req_data = 32'h0000_D1D0; uart_ready = 1'b1;
      #1; chk("to idle grant", 32'(grant), 32'h0);
      @(negedge clk);
      #1; chk("to owner grant", 32'(grant), 32'h1);
      @(negedge clk);
      req_valid = 4'h2;
`ifdef UART_ARB_TIMEOUT_EN
      found  = 1'b0;
      n_wait = 0;
      for (int i = 1; i <= 100 && !found; i++) begin
         @(negedge clk); #1;
         if (timeout) begin
            found  = 1'b1;
            n_wait = i;
         end
      end
      chk("to pulse seen", 32'(found), 32'h1);
      chk("to idle cycles", 32'(n_wait), 32'd20);
      chk("to release grant", 32'(grant), 32'h0);
      chk("to release busy", 32'(busy), 32'h0);
      @(negedge clk); #1;
      chk("to pulse width", 32'(timeout), 32'h0);
      chk("to next grant", 32'(grant), 32'h2);
`else
      to_seen = 0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk); #1;
         if (timeout) to_seen++;
      end
      chk("hold grant", 32'(grant), 32'h1);
      chk("hold busy", 32'(busy), 32'h1);
      chk("hold no timeout", 32'(to_seen), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
